writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Sits directly downstream of the execution units and closes the loop to the instruction scheduler.
- Collects completed results from ALU1, ALU2, ADVINT (two results), MEMUNIT and BRANCH.
- Buffers each result in a one-entry per-source pending slot and drains up to two per cycle to the register-file write ports with round-robin fairness.
- Reports the written register numbers on reg1_finished/reg2_finished so the scheduler can clear its busy bits.

Parameters:
- DATA_W, 64, register data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- src_done  in  6  result-valid per source. Bit 0 alu1, 1 alu2, 2 advint rd, 3 advint rd2, 4 memunit, 5 branch.
- src_rn  in  36  destination register number, 6 bits per source, same index order.
- src_data  in  6*DATA_W  result data, DATA_W bits per source, same index order.
- src_hold  out  6  per-source stall; a unit must not assert src_done while its hold bit is 1.
- wr1_en  out  1  register-file write port 1 enable.
- wr1_rn  out  6  write port 1 register number.
- wr1_data  out  DATA_W  write port 1 data.
- wr2_en  out  1  write port 2 enable.
- wr2_rn  out  6  write port 2 register number.
- wr2_data  out  DATA_W  write port 2 data.
- reg1_finished  out  6  register completed via port 1; 0 when wr1_en=0.
- reg2_finished  out  6  register completed via port 2; 0 when wr2_en=0.

Behaviour:
- Reset: synchronous, taken on a clk edge with rst_n=0. Clears all pending slots, sets the round-robin pointer to 0, and drives all wr*_en/rn/data and reg*_finished outputs to 0.
- Reset mid-operation discards every pending result. No write occurs on the edge where reset is sampled.
- Capture: on each edge, for source i, if src_done[i]=1 and src_hold[i]=0, the slot loads src_rn/src_data and pend_v[i]=1.
- A capture with rn=0 is discarded: r0 is never written or reported, and pend_v stays 0.
- Drain: combinational selection over pend_v. Scan the 6 slots starting at pointer ptr, wrapping 5->0.
  - First valid slot goes to port 1; next valid slot goes to port 2.
  - Port 2 skips any slot whose rn equals port 1's rn; that slot waits at least one more cycle.
- Granted slots clear pend_v on the edge.
- A granted slot may reload from a new src_done on the same edge. Capture takes precedence over clear.
- src_hold[i] = pend_v[i] & ~grant[i], combinational.
- Outputs are registered. The edge that clears a granted slot drives wr*_en=1 with that slot's rn/data; ungranted ports get en=0, rn=0, data=0.
- reg*_finished mirrors wr*_rn when enabled, else 0.
- Latency: a result presented in cycle c appears on a write port no earlier than cycle c+2. Maximum wait under full load is 3 drain cycles (6 slots, 2 per cycle).
- Pointer: on any edge with at least one grant, ptr = (last granted index + 1) mod 6. With no grant, ptr holds.
- Protocol violation: src_done[i] while src_hold[i]=1. The new result is ignored and the pending entry is unchanged. The bench flags this as a unit error.
- Same rn pending in two slots (WAW) must not arise given scheduler busy tracking. If it does, the slots drain in pointer order, one per cycle.

Test Plan:
- Single result: reset, then alu1 done rn=5 data=0xAA in cycle 1 -> cycle 3 has wr1_en=1, wr1_rn=5, wr1_data=0xAA, reg1_finished=5, wr2_en=0, src_hold=0.
- Triple completion: alu1 rn=1, alu2 rn=2, memunit rn=4 in the same cycle, ptr=0 -> next drain writes ports 1/2 with rn 1/2 while src_hold[4]=1; following cycle writes rn 4 on port 1; ptr ends at 5.
- ADVINT dual result: sources 2/3 with rn=10/11 -> both written in one cycle (port1=10, port2=11); reg1_finished=10, reg2_finished=11.
- r0 discard: branch done rn=0 data=0xFF -> no write ever, src_hold[5] stays 0, reg*_finished stay 0.
- Fairness: all 6 sources re-present every cycle they are unheld -> each source is granted at least once in any 3 consecutive drain cycles; no source waits more than 3 cycles.
- Reset mid-op: load 5 slots, assert rst_n=0 for one edge -> all wr*_en=0, src_hold=0, ptr=0; no stale result is ever written afterwards.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Purpose : collect results from six execution-unit sources into one-entry pending slots
//           and drain up to two per cycle, round-robin, to the register-file write ports.
// Latency : a result presented in cycle c is written no earlier than cycle c+2 (capture + registered drain).
// Backpressure: src_hold[i] is raised while slot i holds an undrained result; a held unit must not
//           present a new result, and any result presented while held is ignored.
// Ports   : clk, rst_n (sync, active-low); src_done/src_rn/src_data per-source results
//           (0 alu1, 1 alu2, 2 advint rd, 3 advint rd2, 4 memunit, 5 branch); src_hold per-source stall;
//           wr1_*/wr2_* registered write ports; reg1_finished/reg2_finished completed register numbers.
module writeback_arbiter #(
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            src_done,
   input  logic [35:0]           src_rn,
   input  logic [6*DATA_W-1:0]   src_data,
   output logic [5:0]            src_hold,
   output logic                  wr1_en,
   output logic [5:0]            wr1_rn,
   output logic [DATA_W-1:0]     wr1_data,
   output logic                  wr2_en,
   output logic [5:0]            wr2_rn,
   output logic [DATA_W-1:0]     wr2_data,
   output logic [5:0]            reg1_finished,
   output logic [5:0]            reg2_finished
);

   localparam int NSRC = 6;

   // Pending slots, one per source
   logic [NSRC-1:0]              pend_v_q,    pend_v_d;
   logic [NSRC-1:0][5:0]         pend_rn_q,   pend_rn_d;
   logic [NSRC-1:0][DATA_W-1:0]  pend_data_q, pend_data_d;

   // Round-robin scan start
   logic [2:0]                   ptr_q, ptr_d;

   // Registered write-port outputs
   logic                         wr1_en_q,   wr1_en_d;
   logic [5:0]                   wr1_rn_q,   wr1_rn_d;
   logic [DATA_W-1:0]            wr1_data_q, wr1_data_d;
   logic                         wr2_en_q,   wr2_en_d;
   logic [5:0]                   wr2_rn_q,   wr2_rn_d;
   logic [DATA_W-1:0]            wr2_data_q, wr2_data_d;

   // Drain selection
   logic                         g1_vld, g2_vld;
   logic [2:0]                   g1_idx, g2_idx;
   logic [2:0]                   last_idx;
   logic [3:0]                   scan_sum;
   logic [2:0]                   scan_idx;
   logic [NSRC-1:0]              grant;

   // Walk the slots in pointer order. Port 1 takes the first valid slot; port 2 takes the next
   // valid slot whose register differs from port 1's, so two writes never hit the same register
   // in one cycle. A skipped duplicate simply waits for a later cycle.
   always_comb begin
      g1_vld   = 1'b0;
      g1_idx   = 3'd0;
      g2_vld   = 1'b0;
      g2_idx   = 3'd0;
      scan_sum = 4'd0;
      scan_idx = 3'd0;
      for (int k = 0; k < NSRC; k++) begin
         scan_sum = {1'b0, ptr_q} + 4'(k);
         scan_idx = (scan_sum >= 4'd6) ? 3'(scan_sum - 4'd6) : scan_sum[2:0];
         if (pend_v_q[scan_idx]) begin
            if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = scan_idx;
            end else if (!g2_vld && (pend_rn_q[scan_idx] != pend_rn_q[g1_idx])) begin
               g2_vld = 1'b1;
               g2_idx = scan_idx;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (g1_vld) grant[g1_idx] = 1'b1;
      if (g2_vld) grant[g2_idx] = 1'b1;
   end

   // A slot being drained this cycle is free to accept a new result on the same edge
   assign src_hold = pend_v_q & ~grant;

   // Slot next state: grant clears, capture (which wins) reloads. Results for r0 are dropped.
   always_comb begin
      pend_v_d    = pend_v_q & ~grant;
      pend_rn_d   = pend_rn_q;
      pend_data_d = pend_data_q;
      for (int i = 0; i < NSRC; i++) begin
         if (src_done[i] && !src_hold[i] && (src_rn[i*6 +: 6] != 6'd0)) begin
            pend_v_d[i]    = 1'b1;
            pend_rn_d[i]   = src_rn[i*6 +: 6];
            pend_data_d[i] = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next scan starts just past the last slot granted this cycle
   always_comb begin
      last_idx = g2_vld ? g2_idx : g1_idx;
      if (g1_vld) begin
         ptr_d = (last_idx == 3'd5) ? 3'd0 : last_idx + 3'd1;
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_comb begin
      wr1_en_d   = g1_vld;
      wr1_rn_d   = g1_vld ? pend_rn_q[g1_idx]   : 6'd0;
      wr1_data_d = g1_vld ? pend_data_q[g1_idx] : '0;
      wr2_en_d   = g2_vld;
      wr2_rn_d   = g2_vld ? pend_rn_q[g2_idx]   : 6'd0;
      wr2_data_d = g2_vld ? pend_data_q[g2_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_v_q    <= '0;
         pend_rn_q   <= '0;
         pend_data_q <= '0;
         ptr_q       <= 3'd0;
         wr1_en_q    <= 1'b0;
         wr1_rn_q    <= 6'd0;
         wr1_data_q  <= '0;
         wr2_en_q    <= 1'b0;
         wr2_rn_q    <= 6'd0;
         wr2_data_q  <= '0;
      end else begin
         pend_v_q    <= pend_v_d;
         pend_rn_q   <= pend_rn_d;
         pend_data_q <= pend_data_d;
         ptr_q       <= ptr_d;
         wr1_en_q    <= wr1_en_d;
         wr1_rn_q    <= wr1_rn_d;
         wr1_data_q  <= wr1_data_d;
         wr2_en_q    <= wr2_en_d;
         wr2_rn_q    <= wr2_rn_d;
         wr2_data_q  <= wr2_data_d;
      end
   end

   assign wr1_en        = wr1_en_q;
   assign wr1_rn        = wr1_rn_q;
   assign wr1_data      = wr1_data_q;
   assign wr2_en        = wr2_en_q;
   assign wr2_rn        = wr2_rn_q;
   assign wr2_data      = wr2_data_q;
   // Register numbers are already forced to 0 on idle ports, so these follow them directly
   assign reg1_finished = wr1_rn_q;
   assign reg2_finished = wr2_rn_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Purpose : self-checking bench for writeback_arbiter against a queue-based behavioural model.
// Latency : model output expectations are checked every cycle on the falling edge.
// Backpressure: stimulus only presents results on unheld sources, except one deliberate violation.
module tb_writeback_arbiter;

   localparam int DATA_W = 64;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [5:0]           src_done;
   logic [35:0]          src_rn;
   logic [6*DATA_W-1:0]  src_data;
   logic [5:0]           src_hold;
   logic                 wr1_en, wr2_en;
   logic [5:0]           wr1_rn, wr2_rn;
   logic [DATA_W-1:0]    wr1_data, wr2_data;
   logic [5:0]           reg1_finished, reg2_finished;

   int total = 0;
   int bad   = 0;

   writeback_arbiter #(.DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .src_done      (src_done),
      .src_rn        (src_rn),
      .src_data      (src_data),
      .src_hold      (src_hold),
      .wr1_en        (wr1_en),
      .wr1_rn        (wr1_rn),
      .wr1_data      (wr1_data),
      .wr2_en        (wr2_en),
      .wr2_rn        (wr2_rn),
      .wr2_data      (wr2_data),
      .reg1_finished (reg1_finished),
      .reg2_finished (reg2_finished)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit   [5:0]  mpend = '0;
   logic [5:0]  mrn   [6];
   logic [63:0] mdata [6];
   int          mptr  = 0;
   int          unit_err = 0;
   logic        e1_en = 1'b0, e2_en = 1'b0;
   logic [5:0]  e1_rn = '0,   e2_rn = '0;
   logic [63:0] e1_dat = '0,  e2_dat = '0;

   // Pending sources listed in pointer order; first one wins port 1, next with a different rn wins port 2
   function automatic void model_grant(output int p1, output int p2);
      int order[$];
      p1 = -1;
      p2 = -1;
      for (int k = 0; k < 6; k++)
         if (mpend[(mptr + k) % 6]) order.push_back((mptr + k) % 6);
      if (order.size() > 0) begin
         p1 = order[0];
         for (int j = 1; j < order.size(); j++)
            if (p2 < 0 && mrn[order[j]] != mrn[p1]) p2 = order[j];
      end
   endfunction

   function automatic logic [5:0] model_hold();
      int p1, p2;
      logic [5:0] h;
      model_grant(p1, p2);
      h = mpend;
      if (p1 >= 0) h[p1] = 1'b0;
      if (p2 >= 0) h[p2] = 1'b0;
      return h;
   endfunction

   int         mp1, mp2;
   logic [5:0] mh;
   always @(posedge clk) begin
      if (!rst_n) begin
         mpend = '0;
         mptr  = 0;
         e1_en = 1'b0; e1_rn = '0; e1_dat = '0;
         e2_en = 1'b0; e2_rn = '0; e2_dat = '0;
      end else begin
         model_grant(mp1, mp2);
         mh = model_hold();
         e1_en = 1'b0; e1_rn = '0; e1_dat = '0;
         e2_en = 1'b0; e2_rn = '0; e2_dat = '0;
         if (mp1 >= 0) begin
            e1_en = 1'b1; e1_rn = mrn[mp1]; e1_dat = mdata[mp1];
            mpend[mp1] = 1'b0;
            mptr = (((mp2 >= 0) ? mp2 : mp1) + 1) % 6;
         end
         if (mp2 >= 0) begin
            e2_en = 1'b1; e2_rn = mrn[mp2]; e2_dat = mdata[mp2];
            mpend[mp2] = 1'b0;
         end
         for (int i = 0; i < 6; i++) begin
            if (src_done[i]) begin
               if (mh[i]) unit_err++;
               else if (src_rn[i*6 +: 6] != 6'd0) begin
                  mpend[i] = 1'b1;
                  mrn[i]   = src_rn[i*6 +: 6];
                  mdata[i] = src_data[i*64 +: 64];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cmp_wr1_en",   64'(wr1_en),        64'(e1_en));
      chk("cmp_wr1_rn",   64'(wr1_rn),        64'(e1_rn));
      chk("cmp_wr1_data", wr1_data,           e1_dat);
      chk("cmp_wr2_en",   64'(wr2_en),        64'(e2_en));
      chk("cmp_wr2_rn",   64'(wr2_rn),        64'(e2_rn));
      chk("cmp_wr2_data", wr2_data,           e2_dat);
      chk("cmp_reg1_fin", 64'(reg1_finished), 64'(e1_en ? e1_rn : 6'd0));
      chk("cmp_reg2_fin", 64'(reg2_finished), 64'(e2_en ? e2_rn : 6'd0));
      chk("cmp_src_hold", 64'(src_hold),      64'(model_hold()));
   end

   // ---------------- stimulus ----------------
   task automatic clr_src();
      src_done = '0;
      src_rn   = '0;
      src_data = '0;
   endtask

   task automatic set_src(input int i, input logic [5:0] rn, input logic [63:0] d);
      src_done[i]        = 1'b1;
      src_rn[i*6 +: 6]   = rn;
      src_data[i*64 +: 64] = d;
   endtask

   logic [5:0] seen [24];
   logic [5:0] h;
   int         s;
   logic       cov;

   initial begin
      rst_n = 1'b0;
      clr_src();
      repeat (2) @(negedge clk);
      // reset state
      chk("rst_wr1_en",   64'(wr1_en),        64'd0);
      chk("rst_wr2_en",   64'(wr2_en),        64'd0);
      chk("rst_src_hold", 64'(src_hold),      64'd0);
      chk("rst_reg1_fin", 64'(reg1_finished), 64'd0);

      // single result: alu1 rn=5 data=AA in cycle 1, written in cycle 3
      rst_n = 1'b1;
      set_src(0, 6'd5, 64'hAA);
      @(negedge clk);
      clr_src();
      chk("single_hold_c2", 64'(src_hold), 64'd0);
      @(negedge clk);
      chk("single_wr1_en",   64'(wr1_en),        64'd1);
      chk("single_wr1_rn",   64'(wr1_rn),        64'd5);
      chk("single_wr1_data", wr1_data,           64'hAA);
      chk("single_reg1_fin", 64'(reg1_finished), 64'd5);
      chk("single_wr2_en",   64'(wr2_en),        64'd0);
      chk("single_hold",     64'(src_hold),      64'd0);
      @(negedge clk);
      chk("single_idle_en",  64'(wr1_en),        64'd0);

      // triple completion from ptr=0, plus a held-source violation on memunit
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_src(0, 6'd1, 64'h101);
      set_src(1, 6'd2, 64'h202);
      set_src(4, 6'd4, 64'h404);
      @(negedge clk);
      clr_src();
      chk("triple_hold4", 64'(src_hold), 64'b010000);
      set_src(4, 6'd9, 64'h999);
      @(negedge clk);
      clr_src();
      chk("triple_wr1_rn",   64'(wr1_rn),        64'd1);
      chk("triple_wr1_data", wr1_data,           64'h101);
      chk("triple_wr2_rn",   64'(wr2_rn),        64'd2);
      chk("triple_reg2_fin", 64'(reg2_finished), 64'd2);
      @(negedge clk);
      chk("triple_c3_rn",    64'(wr1_rn),        64'd4);
      chk("triple_c3_data",  wr1_data,           64'h404);
      chk("triple_c3_wr2",   64'(wr2_en),        64'd0);
      chk("model_ptr_5",     64'(mptr),          64'd5);

      // advint dual result
      set_src(2, 6'd10, 64'hA10);
      set_src(3, 6'd11, 64'hB11);
      @(negedge clk);
      clr_src();
      @(negedge clk);
      chk("adv_wr1_rn",   64'(wr1_rn),        64'd10);
      chk("adv_wr2_rn",   64'(wr2_rn),        64'd11);
      chk("adv_reg1_fin", 64'(reg1_finished), 64'd10);
      chk("adv_reg2_fin", 64'(reg2_finished), 64'd11);
      chk("adv_wr2_data", wr2_data,           64'hB11);

      // r0 discard on branch
      set_src(5, 6'd0, 64'hFF);
      @(negedge clk);
      clr_src();
      chk("r0_hold", 64'(src_hold), 64'd0);
      for (int c = 0; c < 3; c++) begin
         chk("r0_no_wr1",  64'(wr1_en),        64'd0);
         chk("r0_no_fin1", 64'(reg1_finished), 64'd0);
         chk("r0_no_fin2", 64'(reg2_finished), 64'd0);
         @(negedge clk);
      end

      // WAW: two slots with rn 7 drain one per cycle in pointer order (ptr=4)
      set_src(0, 6'd7, 64'h70);
      set_src(1, 6'd7, 64'h71);
      @(negedge clk);
      clr_src();
      @(negedge clk);
      chk("waw_c1_data", wr1_data,    64'h70);
      chk("waw_c1_wr2",  64'(wr2_en), 64'd0);
      @(negedge clk);
      chk("waw_c2_data", wr1_data,    64'h71);
      chk("waw_c2_wr2",  64'(wr2_en), 64'd0);
      repeat (2) @(negedge clk);

      // fairness under full load: every source re-presents whenever unheld
      for (int c = 0; c < 24; c++) begin
         h = model_hold();
         clr_src();
         for (int i = 0; i < 6; i++)
            if (!h[i]) set_src(i, 6'(20 + i), {$urandom, $urandom});
         @(negedge clk);
         seen[c] = '0;
         if (wr1_en) begin
            s = int'(reg1_finished) - 20;
            if (s >= 0 && s < 6) seen[c][s] = 1'b1;
         end
         if (wr2_en) begin
            s = int'(reg2_finished) - 20;
            if (s >= 0 && s < 6) seen[c][s] = 1'b1;
         end
      end
      clr_src();
      for (int w = 1; w <= 21; w++)
         for (int i = 0; i < 6; i++) begin
            cov = seen[w][i] | seen[w+1][i] | seen[w+2][i];
            chk("fair_window", 64'(cov), 64'd1);
         end
      repeat (5) @(negedge clk);

      // reset mid-operation with five loaded slots
      for (int i = 0; i < 5; i++) set_src(i, 6'(30 + i), 64'(64'hC0 + i));
      @(negedge clk);
      clr_src();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_wr1_en", 64'(wr1_en),   64'd0);
      chk("mrst_wr2_en", 64'(wr2_en),   64'd0);
      chk("mrst_hold",   64'(src_hold), 64'd0);
      chk("mrst_ptr",    64'(mptr),     64'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("mrst_no_stale", 64'(wr1_en | wr2_en), 64'd0);
      end

      chk("unit_errors", 64'(unit_err), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
      $fatal(1);
   end

endmodule
